// File: rtl/conv_args_pkg.sv
// Shared definitions for the conv argument prefetcher: FSM encoding,
// default tile/packing constants and a ceil-shift helper.
package conv_args_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int          ROWS_MODE0_DEF     = 64;
  localparam int          ROWS_MODE1_DEF     = 128;
  // 4 bits per stream, stream 0 in the low nibble: E=5, bias=6, scale=6
  localparam logic [11:0] EPW_LOG2_DEF       = {4'd6, 4'd6, 4'd5};
  localparam int          APR_LOG2_MODE0_DEF = 0;
  localparam int          APR_LOG2_MODE1_DEF = 1;

  // ceil(v / 2^s), computed in 17 bits so the rounding add cannot wrap
  function automatic logic [15:0] ceil_shr(input logic [15:0] v, input logic [3:0] s);
    logic [16:0] t;
    t = {1'b0, v} + ((17'd1 << s) - 17'd1);
    return 16'(t >> s);
  endfunction

endpackage

// File: rtl/conv_args_stream_ctr.sv
// One argument stream: word counter, read address, grant handshake and
// the RD_LAT delay line that lines register writes up with returned data.
module conv_args_stream_ctr #(
  parameter int EPW_LOG2 = 5,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active_i,     // FSM in FETCH
  input  logic        clr_i,        // FSM in IDLE: rewind word counter
  input  logic [15:0] nwords_i,
  input  logic [15:0] adr_base_i,
  input  logic [15:0] tile_size_i,
  input  logic [3:0]  apr_log2_i,
  input  logic        rd_gnt_i,
  output logic        rd_en_o,
  output logic [15:0] rd_adr_o,
  output logic        done_o,
  output logic        reg_wr_en_o,
  output logic [7:0]  reg_start_o,
  output logic [7:0]  reg_size_o
);

  localparam logic [16:0] EPW_N = 17'd1 << EPW_LOG2;

  logic [15:0] w_q, w_d;
  logic        fire;
  logic [16:0] consumed, remain, sz_full;
  logic [7:0]  start_in, size_in;

  logic [RD_LAT-1:0] vld_q;
  logic [7:0]        start_q [RD_LAT];
  logic [7:0]        size_q  [RD_LAT];

  // rd_en/rd_adr depend only on state, so they hold while the grant is low
  assign rd_en_o  = active_i && (w_q < nwords_i);
  assign rd_adr_o = adr_base_i + w_q;
  assign done_o   = (w_q >= nwords_i);
  assign fire     = rd_en_o && rd_gnt_i;

  // register-file write descriptor for the word being granted this cycle
  assign consumed = {1'b0, w_q} << EPW_LOG2;
  assign remain   = {1'b0, tile_size_i} - consumed;
  assign sz_full  = (remain < EPW_N) ? remain : EPW_N;
  assign start_in = 8'(w_q) * 8'(EPW_N >> apr_log2_i);
  assign size_in  = 8'(sz_full >> apr_log2_i);

  // next word index: rewind in IDLE, advance only on a granted read
  always_comb begin
    w_d = w_q;
    if (clr_i)     w_d = '0;
    else if (fire) w_d = w_q + 16'd1;
  end

  // word counter register
  always_ff @(posedge clk) begin
    if (reset) w_q <= '0;
    else       w_q <= w_d;
  end

  // delay line; idle slots carry zeros so start/size read 0 without a write
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        start_q[k] <= '0;
        size_q[k]  <= '0;
      end
    end else begin
      vld_q[0]   <= fire;
      start_q[0] <= fire ? start_in : 8'd0;
      size_q[0]  <= fire ? size_in  : 8'd0;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k]   <= vld_q[k-1];
        start_q[k] <= start_q[k-1];
        size_q[k]  <= size_q[k-1];
      end
    end
  end

  assign reg_wr_en_o = vld_q[RD_LAT-1];
  assign reg_start_o = start_q[RD_LAT-1];
  assign reg_size_o  = size_q[RD_LAT-1];

endmodule

// File: rtl/conv_args_prefetcher.sv
// Per-tile prefetcher for per-output-channel conv arguments (E, bias, scale).
// Walks output-channel tiles of a layer, issues buffer reads per stream and
// emits register-file write descriptors aligned with the read data.
// Optional: define CONV_ARGS_PREFETCH_ERR_CHK_EN to add err_sticky_o.
module conv_args_prefetcher
  import conv_args_pkg::*;
#(
  parameter int                      NUM_ARGS       = 3,
  parameter logic [4*NUM_ARGS-1:0]   EPW_LOG2       = EPW_LOG2_DEF,
  parameter int                      ROWS_MODE0     = ROWS_MODE0_DEF,
  parameter int                      ROWS_MODE1     = ROWS_MODE1_DEF,
  parameter int                      APR_LOG2_MODE0 = APR_LOG2_MODE0_DEF,
  parameter int                      APR_LOG2_MODE1 = APR_LOG2_MODE1_DEF,
  parameter int                      RD_LAT         = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_load_i,
  input  logic [15:0]              cfg_of_i,
  input  logic                     cfg_mode_i,
  input  logic [16*NUM_ARGS-1:0]   cfg_base_i,
  input  logic                     tile_req_i,
  output logic                     busy_o,
  output logic                     tile_done_o,
  output logic                     layer_done_o,
  output logic [15:0]              tile_idx_o,
  output logic [NUM_ARGS-1:0]      rd_en_o,
  output logic [16*NUM_ARGS-1:0]   rd_adr_o,
  input  logic [NUM_ARGS-1:0]      rd_gnt_i,
  output logic [NUM_ARGS-1:0]      reg_wr_en_o,
  output logic [8*NUM_ARGS-1:0]    reg_start_o,
  output logic [8*NUM_ARGS-1:0]    reg_size_o
`ifdef CONV_ARGS_PREFETCH_ERR_CHK_EN
  ,
  output logic                     err_sticky_o
`endif
);

  state_e state_q, state_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [15:0] tile_idx_q, tile_idx_d;
  logic [15:0] of_q;
  logic        mode_q;
  logic [16*NUM_ARGS-1:0] base_q;

  logic [15:0] rows, tof_start, remain, tile_size;
  logic [3:0]  apr;
  logic        last_tile, all_done;
  logic        tile_done, layer_done;
  logic [NUM_ARGS-1:0] done;
  logic [NUM_ARGS-1:0][15:0] nwords, adr_base;

  assign busy_o       = (state_q != ST_IDLE);
  assign tile_done_o  = tile_done;
  assign layer_done_o = layer_done;
  assign tile_idx_o   = tile_idx_q;

  // tile geometry derived from latched config and current tile index
  assign rows      = cfg_mode_sel(mode_q);
  assign apr       = mode_q ? 4'(APR_LOG2_MODE1) : 4'(APR_LOG2_MODE0);
  assign tof_start = tile_idx_q * rows;
  assign remain    = (of_q > tof_start) ? (of_q - tof_start) : 16'd0;
  assign tile_size = (remain < rows) ? remain : rows;
  assign last_tile = ({1'b0, tof_start} + {1'b0, rows}) >= {1'b0, of_q};
  assign all_done  = &done;

  function automatic logic [15:0] cfg_mode_sel(input logic m);
    return m ? 16'(ROWS_MODE1) : 16'(ROWS_MODE0);
  endfunction

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_stream
    localparam int EPW = int'(EPW_LOG2[4*g +: 4]);
    assign nwords[g]   = ceil_shr(tile_size, 4'(EPW));
    assign adr_base[g] = base_q[16*g +: 16] + (tof_start >> EPW);

    conv_args_stream_ctr #(
      .EPW_LOG2 (EPW),
      .RD_LAT   (RD_LAT)
    ) u_ctr (
      .clk         (clk),
      .reset       (reset),
      .active_i    (state_q == ST_FETCH),
      .clr_i       (state_q == ST_IDLE),
      .nwords_i    (nwords[g]),
      .adr_base_i  (adr_base[g]),
      .tile_size_i (tile_size),
      .apr_log2_i  (apr),
      .rd_gnt_i    (rd_gnt_i[g]),
      .rd_en_o     (rd_en_o[g]),
      .rd_adr_o    (rd_adr_o[16*g +: 16]),
      .done_o      (done[g]),
      .reg_wr_en_o (reg_wr_en_o[g]),
      .reg_start_o (reg_start_o[8*g +: 8]),
      .reg_size_o  (reg_size_o[8*g +: 8])
    );
  end

  // layer config is only accepted while idle so a tile never sees it change
  always_ff @(posedge clk) begin
    if (reset) begin
      of_q   <= '0;
      mode_q <= 1'b0;
      base_q <= '0;
    end else if (cfg_load_i && !busy_o) begin
      of_q   <= cfg_of_i;
      mode_q <= cfg_mode_i;
      base_q <= cfg_base_i;
    end
  end

  // FSM, drain counter and tile index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dcnt_q     <= '0;
      tile_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      tile_idx_q <= tile_idx_d;
    end
  end

  // next state; DRAIN waits out the read latency so the last write lands first
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    tile_idx_d = tile_idx_q;
    tile_done  = 1'b0;
    layer_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dcnt_d = '0;
        if (tile_req_i) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (all_done) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 3'(RD_LAT - 1)) begin
          state_d   = ST_IDLE;
          tile_done = 1'b1;
          if (last_tile) begin
            tile_idx_d = '0;
            layer_done = 1'b1;
          end else begin
            tile_idx_d = tile_idx_q + 16'd1;
          end
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CONV_ARGS_PREFETCH_ERR_CHK_EN
  logic err_q;
  logic rows_bad;

  // a tile that is not a whole number of buffer words breaks address math
  always_comb begin
    rows_bad = 1'b0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if ((rows & ((16'd1 << EPW_LOG2[4*i +: 4]) - 16'd1)) != 16'd0) rows_bad = 1'b1;
    end
  end

  // sticky protocol/config error flag
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (tile_req_i && busy_o) | (cfg_load_i && busy_o) | rows_bad;
  end

  assign err_sticky_o = err_q;
`endif

endmodule

// File: tb/tb_conv_args_prefetcher.sv
// Directed bench: RD_LAT=1 instance checked in detail, RD_LAT=3 instance
// sharing the same stimulus for latency checks.
module tb_conv_args_prefetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_load, cfg_mode, tile_req;
  logic [15:0] cfg_of;
  logic [47:0] cfg_base;
  logic [2:0]  rd_gnt;

  logic        busy, tile_done, layer_done;
  logic [15:0] tile_idx;
  logic [2:0]  rd_en, reg_wr_en;
  logic [47:0] rd_adr;
  logic [23:0] reg_start, reg_size;

  logic        busy2, tile_done2, layer_done2;
  logic [15:0] tile_idx2;
  logic [2:0]  rd_en2, reg_wr_en2;
  logic [47:0] rd_adr2;
  logic [23:0] reg_start2, reg_size2;

  conv_args_prefetcher dut (
    .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_of_i(cfg_of),
    .cfg_mode_i(cfg_mode), .cfg_base_i(cfg_base), .tile_req_i(tile_req),
    .busy_o(busy), .tile_done_o(tile_done), .layer_done_o(layer_done),
    .tile_idx_o(tile_idx), .rd_en_o(rd_en), .rd_adr_o(rd_adr), .rd_gnt_i(rd_gnt),
    .reg_wr_en_o(reg_wr_en), .reg_start_o(reg_start), .reg_size_o(reg_size)
  );

  conv_args_prefetcher #(.RD_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .cfg_load_i(cfg_load), .cfg_of_i(cfg_of),
    .cfg_mode_i(cfg_mode), .cfg_base_i(cfg_base), .tile_req_i(tile_req),
    .busy_o(busy2), .tile_done_o(tile_done2), .layer_done_o(layer_done2),
    .tile_idx_o(tile_idx2), .rd_en_o(rd_en2), .rd_adr_o(rd_adr2), .rd_gnt_i(rd_gnt),
    .reg_wr_en_o(reg_wr_en2), .reg_start_o(reg_start2), .reg_size_o(reg_size2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // capture of one tile run
  int          n_rd [3];
  logic [15:0] rd_a [3][16];
  int          rd_c [3][16];
  int          n_wr [3];
  logic [7:0]  wr_st [3][16];
  logic [7:0]  wr_sz [3][16];
  int          wr_c [3][16];
  int          n_wr2 [3];
  logic [7:0]  wr_sz2 [3][16];
  int          wr_c2 [3][16];
  int          done_c, done_c2, n_rden;
  logic        ld_at_done, adr_moved;
  logic [15:0] stall_adr;

  task automatic load_cfg(input logic [15:0] of, input logic mode, input logic [47:0] base);
    @(negedge clk);
    cfg_of = of; cfg_mode = mode; cfg_base = base; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // request one tile and record reads/writes/done per cycle t after the request
  task automatic run_tile(input logic [2:0] smask, input int scyc, input bit poke);
    logic [2:0]  g;
    logic [15:0] a;
    logic [15:0] of_save;
    of_save = cfg_of;
    for (int s = 0; s < 3; s++) begin n_rd[s] = 0; n_wr[s] = 0; n_wr2[s] = 0; end
    done_c = -1; done_c2 = -1; n_rden = 0; ld_at_done = 1'b0; adr_moved = 1'b0; stall_adr = '0;
    g = '0;
    @(negedge clk);
    tile_req = 1'b1; rd_gnt = '0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      tile_req = 1'b0; cfg_load = 1'b0;
      if (poke && t == 2) begin cfg_load = 1'b1; cfg_of = 16'd5; tile_req = 1'b1; end
      if (poke && t == 3) cfg_of = of_save;
      for (int s = 0; s < 3; s++) begin
        g[s] = !(smask[s] && t <= scyc);
        a = rd_adr[16*s +: 16];
        if (rd_en[s]) n_rden++;
        if (smask[s] && t <= scyc) begin
          if (t == 1) stall_adr = a;
          if (!rd_en[s] || a != stall_adr) adr_moved = 1'b1;
        end
        if (rd_en[s] && g[s] && n_rd[s] < 16) begin
          rd_a[s][n_rd[s]] = a; rd_c[s][n_rd[s]] = t; n_rd[s]++;
        end
        if (reg_wr_en[s] && n_wr[s] < 16) begin
          wr_st[s][n_wr[s]] = reg_start[8*s +: 8]; wr_sz[s][n_wr[s]] = reg_size[8*s +: 8];
          wr_c[s][n_wr[s]] = t; n_wr[s]++;
        end
        if (reg_wr_en2[s] && n_wr2[s] < 16) begin
          wr_sz2[s][n_wr2[s]] = reg_size2[8*s +: 8]; wr_c2[s][n_wr2[s]] = t; n_wr2[s]++;
        end
      end
      rd_gnt = g;
      if (tile_done && done_c < 0) begin done_c = t; ld_at_done = layer_done; end
      if (tile_done2 && done_c2 < 0) done_c2 = t;
      if (done_c >= 0 && done_c2 >= 0) break;
    end
    @(negedge clk);
    rd_gnt = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cfg_load = 1'b0; cfg_mode = 1'b0; tile_req = 1'b0;
    cfg_of = '0; cfg_base = '0; rd_gnt = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy); end
    n_chk++; if (tile_idx !== 16'd0) begin n_fail++; $display("FAIL reset_tile_idx got %0d want 0", tile_idx); end
    n_chk++; if ({tile_done, layer_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", {tile_done, layer_done}); end
    n_chk++; if ({rd_en, reg_wr_en} !== 6'd0) begin n_fail++; $display("FAIL reset_en got %b want 0", {rd_en, reg_wr_en}); end
    n_chk++; if ({reg_start, reg_size} !== 48'd0) begin n_fail++; $display("FAIL reset_reg got %h want 0", {reg_start, reg_size}); end
    n_chk++; if (rd_adr !== 48'd0) begin n_fail++; $display("FAIL reset_adr got %h want 0", rd_adr); end
    n_chk++; if ({busy2, tile_done2, layer_done2, rd_en2, reg_wr_en2} !== 9'd0) begin n_fail++; $display("FAIL reset_dut2_ctl got %b want 0", {busy2, tile_done2, layer_done2, rd_en2, reg_wr_en2}); end
    n_chk++; if ({tile_idx2, rd_adr2, reg_start2, reg_size2} !== 112'd0) begin n_fail++; $display("FAIL reset_dut2_data got nonzero want 0"); end
  endtask

  task automatic test_of100;
    load_cfg(16'd100, 1'b0, {16'h0030, 16'h0020, 16'h0010});
    run_tile(3'b000, 0, 1'b1);  // also pokes cfg_load/tile_req while busy
    n_chk++; if (n_rd[0] !== 2) begin n_fail++; $display("FAIL t0_e_nrd got %0d want 2", n_rd[0]); end
    n_chk++; if ({rd_a[0][0], rd_a[0][1]} !== {16'h10, 16'h11}) begin n_fail++; $display("FAIL t0_e_adr got %h %h want 10 11", rd_a[0][0], rd_a[0][1]); end
    n_chk++; if ({wr_sz[0][0], wr_sz[0][1]} !== {8'd32, 8'd32}) begin n_fail++; $display("FAIL t0_e_size got %0d %0d want 32 32", wr_sz[0][0], wr_sz[0][1]); end
    n_chk++; if ({wr_st[0][0], wr_st[0][1]} !== {8'd0, 8'd32}) begin n_fail++; $display("FAIL t0_e_start got %0d %0d want 0 32", wr_st[0][0], wr_st[0][1]); end
    n_chk++; if (wr_c[0][0] !== 2) begin n_fail++; $display("FAIL t0_e_wr_lat got %0d want 2", wr_c[0][0]); end
    n_chk++; if (rd_a[1][0] !== 16'h20 || wr_sz[1][0] !== 8'd64) begin n_fail++; $display("FAIL t0_bias got adr %h size %0d want 20 64", rd_a[1][0], wr_sz[1][0]); end
    n_chk++; if (done_c !== 4) begin n_fail++; $display("FAIL t0_done_cyc got %0d want 4", done_c); end
    n_chk++; if (ld_at_done !== 1'b0) begin n_fail++; $display("FAIL t0_layer_done got %0d want 0", ld_at_done); end
    n_chk++; if (tile_idx !== 16'd1) begin n_fail++; $display("FAIL t0_tile_idx got %0d want 1", tile_idx); end
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if ({rd_a[0][0], rd_a[0][1]} !== {16'h12, 16'h13}) begin n_fail++; $display("FAIL t1_e_adr got %h %h want 12 13", rd_a[0][0], rd_a[0][1]); end
    n_chk++; if ({wr_sz[0][0], wr_sz[0][1]} !== {8'd32, 8'd4}) begin n_fail++; $display("FAIL t1_e_size got %0d %0d want 32 4", wr_sz[0][0], wr_sz[0][1]); end
    n_chk++; if (wr_st[0][1] !== 8'd32) begin n_fail++; $display("FAIL t1_e_start got %0d want 32", wr_st[0][1]); end
    n_chk++; if (rd_a[2][0] !== 16'h31 || wr_sz[2][0] !== 8'd36) begin n_fail++; $display("FAIL t1_scale got adr %h size %0d want 31 36", rd_a[2][0], wr_sz[2][0]); end
    n_chk++; if (ld_at_done !== 1'b1) begin n_fail++; $display("FAIL t1_layer_done got %0d want 1", ld_at_done); end
    n_chk++; if (tile_idx !== 16'd0) begin n_fail++; $display("FAIL t1_tile_idx got %0d want 0", tile_idx); end
  endtask

  task automatic test_mode1;
    load_cfg(16'd128, 1'b1, {16'h0080, 16'h0040, 16'h0000});
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if (n_rd[1] !== 2) begin n_fail++; $display("FAIL m1_bias_nrd got %0d want 2", n_rd[1]); end
    n_chk++; if ({rd_a[1][0], rd_a[1][1]} !== {16'h40, 16'h41}) begin n_fail++; $display("FAIL m1_bias_adr got %h %h want 40 41", rd_a[1][0], rd_a[1][1]); end
    n_chk++; if ({wr_sz[1][0], wr_sz[1][1]} !== {8'd32, 8'd32}) begin n_fail++; $display("FAIL m1_bias_size got %0d %0d want 32 32", wr_sz[1][0], wr_sz[1][1]); end
    n_chk++; if ({wr_st[1][0], wr_st[1][1]} !== {8'd0, 8'd32}) begin n_fail++; $display("FAIL m1_bias_start got %0d %0d want 0 32", wr_st[1][0], wr_st[1][1]); end
    n_chk++; if (n_rd[0] !== 4 || wr_st[0][3] !== 8'd48 || wr_sz[0][3] !== 8'd16) begin n_fail++; $display("FAIL m1_e_last got n %0d start %0d size %0d want 4 48 16", n_rd[0], wr_st[0][3], wr_sz[0][3]); end
    n_chk++; if (done_c !== 6) begin n_fail++; $display("FAIL m1_done_cyc got %0d want 6", done_c); end
    n_chk++; if (ld_at_done !== 1'b1 || tile_idx !== 16'd0) begin n_fail++; $display("FAIL m1_layer got ld %0d idx %0d want 1 0", ld_at_done, tile_idx); end
  endtask

  task automatic test_stall;
    run_tile(3'b001, 3, 1'b0);
    n_chk++; if (adr_moved !== 1'b0) begin n_fail++; $display("FAIL stall_adr_stable got moved=%0d want 0", adr_moved); end
    n_chk++; if (rd_c[0][0] !== 4 || n_rd[0] !== 4) begin n_fail++; $display("FAIL stall_e_grant got cyc %0d n %0d want 4 4", rd_c[0][0], n_rd[0]); end
    n_chk++; if (n_rd[1] !== 2 || rd_c[1][1] !== 2) begin n_fail++; $display("FAIL stall_bias got n %0d cyc %0d want 2 2", n_rd[1], rd_c[1][1]); end
    n_chk++; if (n_rd[2] !== 2 || rd_c[2][1] !== 2) begin n_fail++; $display("FAIL stall_scale got n %0d cyc %0d want 2 2", n_rd[2], rd_c[2][1]); end
    n_chk++; if (done_c !== 9) begin n_fail++; $display("FAIL stall_done_cyc got %0d want 9", done_c); end
  endtask

  task automatic test_rdlat3;
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if (n_wr2[0] !== 4) begin n_fail++; $display("FAIL lat3_e_nwr got %0d want 4", n_wr2[0]); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (wr_c2[0][k] !== k + 4) begin n_fail++; $display("FAIL lat3_e_wr%0d got cyc %0d want %0d", k, wr_c2[0][k], k + 4); end
    end
    n_chk++; if (wr_sz2[1][0] !== 8'd32 || wr_c2[1][1] !== 5) begin n_fail++; $display("FAIL lat3_bias got size %0d cyc %0d want 32 5", wr_sz2[1][0], wr_c2[1][1]); end
    n_chk++; if (done_c2 !== 8) begin n_fail++; $display("FAIL lat3_done_cyc got %0d want 8", done_c2); end
  endtask

  task automatic test_of0;
    load_cfg(16'd0, 1'b0, {16'h0030, 16'h0020, 16'h0010});
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if (n_rden !== 0) begin n_fail++; $display("FAIL of0_rd_en got %0d cycles want 0", n_rden); end
    n_chk++; if (done_c !== 2 || done_c2 !== 4) begin n_fail++; $display("FAIL of0_done_cyc got %0d %0d want 2 4", done_c, done_c2); end
    n_chk++; if (ld_at_done !== 1'b1 || tile_idx !== 16'd0) begin n_fail++; $display("FAIL of0_layer got ld %0d idx %0d want 1 0", ld_at_done, tile_idx); end
  endtask

  task automatic test_reset_mid;
    load_cfg(16'd100, 1'b0, {16'h0030, 16'h0020, 16'h0010});
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if (tile_idx !== 16'd1) begin n_fail++; $display("FAIL rm_pre_idx got %0d want 1", tile_idx); end
    @(negedge clk); tile_req = 1'b1; rd_gnt = 3'b111;
    @(negedge clk); tile_req = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy got %0d want 1", busy); end
    @(negedge clk); reset = 1'b1; rd_gnt = '0;
    @(negedge clk); reset = 1'b0;
    n_chk++; if (busy !== 1'b0 || tile_idx !== 16'd0) begin n_fail++; $display("FAIL rm_state got busy %0d idx %0d want 0 0", busy, tile_idx); end
    n_chk++; if ({rd_en, reg_wr_en, reg_wr_en2} !== 9'd0) begin n_fail++; $display("FAIL rm_outputs got %b want 0", {rd_en, reg_wr_en, reg_wr_en2}); end
    @(negedge clk);
    n_chk++; if (reg_wr_en2 !== 3'd0) begin n_fail++; $display("FAIL rm_pipe_flush got %b want 0", reg_wr_en2); end
    run_tile(3'b000, 0, 1'b0);  // config was cleared: acts as an empty layer
    n_chk++; if (n_rden !== 0 || ld_at_done !== 1'b1) begin n_fail++; $display("FAIL rm_cfg_clear got rden %0d ld %0d want 0 1", n_rden, ld_at_done); end
    load_cfg(16'd100, 1'b0, {16'h0030, 16'h0020, 16'h0010});
    run_tile(3'b000, 0, 1'b0);
    n_chk++; if ({rd_a[0][0], rd_a[0][1]} !== {16'h10, 16'h11}) begin n_fail++; $display("FAIL rm_e_adr got %h %h want 10 11", rd_a[0][0], rd_a[0][1]); end
    n_chk++; if (rd_a[1][0] !== 16'h20 || tile_idx !== 16'd1) begin n_fail++; $display("FAIL rm_bias got adr %h idx %0d want 20 1", rd_a[1][0], tile_idx); end
  endtask

  initial begin
    test_reset;
    test_of100;
    test_mode1;
    test_stall;
    test_rdlat3;
    test_of0;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
